// File: rtl/sys_csr_trap_pkg.sv
// sys_csr_trap_pkg: CSR addresses, cause codes, status/enable bit positions and trap FSM states
package sys_csr_trap_pkg;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MTIMECMP  = 12'h7C0;
    localparam logic [11:0] CSR_MTIMECMPH = 12'h7C1;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_TIME      = 12'hC01;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_TIMEH     = 12'hC81;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [4:0] CAUSE_ECALL = 5'd11;
    localparam logic [4:0] CAUSE_TIMER = 5'd7;
    localparam logic [4:0] CAUSE_EXT   = 5'd11;
    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MTIE_BIT = 7;
    localparam int MEIE_BIT = 11;
    localparam int MTIP_BIT = 7;
    localparam int MEIP_BIT = 11;
    typedef enum logic [1:0] {IDLE, REQ, ENTER} trap_state_e;
endpackage

// File: rtl/sys_csr_timer.sv
// sys_csr_timer: mtime prescaler/counter and mtimecmp compare
//   cmp_lo_we/cmp_hi_we + wdata write mtimecmp[31:0] / mtimecmp[CNT_W-1:32]
//   mtime, mtimecmp are the live registers, mtip = mtime >= mtimecmp (unsigned)
module sys_csr_timer #(
    parameter int CNT_W    = 64,
    parameter int TIME_DIV = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmp_lo_we,
    input  logic             cmp_hi_we,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] mtime,
    output logic [CNT_W-1:0] mtimecmp,
    output logic             mtip
);
    localparam int PW = $clog2(TIME_DIV);
    logic [PW-1:0] presc;
    logic          tick;
    assign tick = presc == PW'(TIME_DIV - 1);
    assign mtip = mtime >= mtimecmp;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc    <= '0;
            mtime    <= '0;
            mtimecmp <= '1;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            mtime <= mtime + CNT_W'(tick);
            if (cmp_lo_we) mtimecmp[31:0] <= wdata;
            if (cmp_hi_we) mtimecmp[CNT_W-1:32] <= wdata[CNT_W-33:0];
        end
    end
endmodule

// File: rtl/sys_csr_trap.sv
// sys_csr_trap: machine-mode CSR file, counters, timer and interrupt/trap sequencing
//   instr_vld/instr/pc/rs0_word: issued instruction and its rs1 operand
//   retire: instruction retired, irq_ext: async external interrupt level
//   trap_ack/trap_pc: pipeline drained for interrupt entry, resume pc
//   trap_req: interrupt entry requested, jump_vld/jump_pc: fetch redirect
//   csr_data/csr_illegal: pre-write CSR value for rd, illegal access flag
module sys_csr_trap #(
    parameter int XLEN     = 32,
    parameter int CNT_W    = 64,
    parameter int TIME_DIV = 100,
    parameter int HARTID   = 0,
    parameter int VEC_EN   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_vld,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs0_word,
    input  logic            retire,
    input  logic            irq_ext,
    input  logic            trap_ack,
    input  logic [XLEN-1:0] trap_pc,
    output logic            trap_req,
    output logic            jump_vld,
    output logic [XLEN-1:0] jump_pc,
    output logic [XLEN-1:0] csr_data,
    output logic            csr_illegal
);
    import sys_csr_trap_pkg::*;
    localparam int HW = CNT_W - 32;
    trap_state_e      state;
    logic             st_mie, st_mpie, meie, mtie, irq_s1, meip, mtip, pend;
    logic [XLEN-1:0]  mtvec, mscratch, mepc, mcause, src, rdata, wdata, base, trap_tgt;
    logic [CNT_W-1:0] mcycle, minstret, mtime, mtimecmp;
    logic [11:0]      addr;
    logic [4:0]       fld;
    logic [2:0]       f3;
    logic             issue, csr_op, ecall, mret, fence_i, wr, ro, legal, ill, we;
    assign addr    = instr[31:20];
    assign fld     = instr[19:15];
    assign f3      = instr[14:12];
    // reset gates the combinational redirect/illegal paths so outputs are quiet while rst is low
    assign issue   = instr_vld & rst & (state == IDLE);
    assign csr_op  = issue & (instr[6:0] == 7'h73) & (f3[1:0] != 2'b00);
    assign ecall   = issue & (instr == XLEN'(32'h0000_0073));
    assign mret    = issue & (instr == XLEN'(32'h3020_0073));
    assign fence_i = issue & (instr[6:0] == 7'h0F) & (f3 == 3'b001);
    assign src     = f3[2] ? XLEN'(fld) : rs0_word;
    assign wr      = (f3[1:0] == 2'b01) | (fld != '0);
    assign ro      = (addr[11:8] == 4'hC) | (addr == CSR_MHARTID);
    assign ill     = csr_op & (~legal | (wr & ro));
    assign we      = csr_op & wr & ~ill;
    assign wdata   = f3[1:0] == 2'b01 ? src : f3[1:0] == 2'b10 ? rdata | src : rdata & ~src;
    assign pend    = st_mie & ((meie & meip) | (mtie & mtip));
    assign base    = mtvec & ~XLEN'(3);
    assign trap_tgt = (mtvec[0] && VEC_EN != 0) ? base + XLEN'({mcause[4:0], 2'b00}) : base;
    assign trap_req    = state == REQ;
    assign jump_vld    = (state == ENTER) | ecall | mret | fence_i;
    assign jump_pc     = state == ENTER ? trap_tgt : ecall ? base : mret ? mepc : fence_i ? pc + XLEN'(4) : '0;
    assign csr_data    = csr_op & ~ill ? rdata : '0;
    assign csr_illegal = ill;
    always_comb begin
        legal = 1'b1;
        rdata = '0;
        case (addr)
            CSR_MSTATUS: begin rdata[MIE_BIT] = st_mie; rdata[MPIE_BIT] = st_mpie; end
            CSR_MIE:     begin rdata[MEIE_BIT] = meie; rdata[MTIE_BIT] = mtie; end
            CSR_MIP:     begin rdata[MEIP_BIT] = meip; rdata[MTIP_BIT] = mtip; end
            CSR_MTVEC:     rdata = mtvec;
            CSR_MSCRATCH:  rdata = mscratch;
            CSR_MEPC:      rdata = mepc;
            CSR_MCAUSE:    rdata = mcause;
            CSR_MHARTID:   rdata = XLEN'(HARTID);
            CSR_MTIMECMP:  rdata = XLEN'(mtimecmp[31:0]);
            CSR_MTIMECMPH: rdata = XLEN'(mtimecmp[CNT_W-1:32]);
            CSR_MCYCLE, CSR_CYCLE:       rdata = XLEN'(mcycle[31:0]);
            CSR_MCYCLEH, CSR_CYCLEH:     rdata = XLEN'(mcycle[CNT_W-1:32]);
            CSR_MINSTRET, CSR_INSTRET:   rdata = XLEN'(minstret[31:0]);
            CSR_MINSTRETH, CSR_INSTRETH: rdata = XLEN'(minstret[CNT_W-1:32]);
            CSR_TIME:  rdata = XLEN'(mtime[31:0]);
            CSR_TIMEH: rdata = XLEN'(mtime[CNT_W-1:32]);
            default: legal = 1'b0;
        endcase
    end
    sys_csr_timer #(.CNT_W(CNT_W), .TIME_DIV(TIME_DIV)) u_timer (
        .clk(clk),
        .rst(rst),
        .cmp_lo_we(we & (addr == CSR_MTIMECMP)),
        .cmp_hi_we(we & (addr == CSR_MTIMECMPH)),
        .wdata(wdata[31:0]),
        .mtime(mtime),
        .mtimecmp(mtimecmp),
        .mtip(mtip)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            st_mie   <= 1'b0;
            st_mpie  <= 1'b0;
            meie     <= 1'b0;
            mtie     <= 1'b0;
            irq_s1   <= 1'b0;
            meip     <= 1'b0;
            mtvec    <= '0;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            irq_s1 <= irq_ext;
            meip   <= irq_s1;
            // a CSR write to either half replaces that cycle's increment
            mcycle <= we & (addr == CSR_MCYCLE)  ? {mcycle[CNT_W-1:32], wdata[31:0]} :
                      we & (addr == CSR_MCYCLEH) ? {wdata[HW-1:0], mcycle[31:0]} : mcycle + 1'b1;
            minstret <= we & (addr == CSR_MINSTRET)  ? {minstret[CNT_W-1:32], wdata[31:0]} :
                        we & (addr == CSR_MINSTRETH) ? {wdata[HW-1:0], minstret[31:0]} : minstret + CNT_W'(retire);
            if (we & (addr == CSR_MTVEC)) mtvec <= wdata;
            if (we & (addr == CSR_MSCRATCH)) mscratch <= wdata;
            if (we & (addr == CSR_MEPC)) mepc <= wdata & ~XLEN'(3);
            if (we & (addr == CSR_MCAUSE)) mcause <= wdata;
            if (we & (addr == CSR_MSTATUS)) begin
                st_mie  <= wdata[MIE_BIT];
                st_mpie <= wdata[MPIE_BIT];
            end
            if (we & (addr == CSR_MIE)) begin
                meie <= wdata[MEIE_BIT];
                mtie <= wdata[MTIE_BIT];
            end
            if (ecall) begin
                mepc    <= pc & ~XLEN'(3);
                mcause  <= XLEN'(CAUSE_ECALL);
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
            end
            if (mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end
            case (state)
                IDLE: if (pend) state <= REQ;
                REQ: begin
                    if (!pend) state <= IDLE;
                    else if (trap_ack) begin
                        state   <= ENTER;
                        mepc    <= trap_pc & ~XLEN'(3);
                        mcause  <= {1'b1, (XLEN-1)'(meie & meip ? CAUSE_EXT : CAUSE_TIMER)};
                        st_mpie <= st_mie;
                        st_mie  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sys_csr_trap.sv
// tb_sys_csr_trap: random CSR traffic plus directed trap scenarios against a behavioural model
module tb_sys_csr_trap;
    localparam int TD = 4;
    logic clk = 1'b0, rst = 1'b0;
    logic instr_vld = 1'b0, retire = 1'b0, irq_ext = 1'b0, trap_ack = 1'b0;
    logic [31:0] instr = '0, pc = '0, rs0_word = '0, trap_pc = '0;
    logic trap_req, jump_vld, csr_illegal;
    logic [31:0] jump_pc, csr_data;
    int checks = 0, errors = 0;
    logic [31:0] m_mst, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cyc, m_ins, m_cmp, ncyc, o_n;
    logic irq_h1, irq_h2;
    logic o_jv, o_treq, o_ill;
    logic [31:0] o_jpc, o_data;
    logic [11:0] alist [22] = '{12'h300, 12'h304, 12'h344, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF14,
                                12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC01, 12'hC02, 12'hC80,
                                12'hC81, 12'hC82, 12'h301, 12'h7C2, 12'h123, 12'hB03};

    sys_csr_trap #(.XLEN(32), .CNT_W(64), .TIME_DIV(TD), .HARTID(5), .VEC_EN(1)) dut (
        .clk(clk), .rst(rst), .instr_vld(instr_vld), .instr(instr), .pc(pc), .rs0_word(rs0_word),
        .retire(retire), .irq_ext(irq_ext), .trap_ack(trap_ack), .trap_pc(trap_pc),
        .trap_req(trap_req), .jump_vld(jump_vld), .jump_pc(jump_pc),
        .csr_data(csr_data), .csr_illegal(csr_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mst = '0; m_mie = '0; m_mtvec = '0; m_mscratch = '0; m_mepc = '0; m_mcause = '0;
        m_cyc = '0; m_ins = '0; m_cmp = '1; ncyc = '0; irq_h1 = 1'b0; irq_h2 = 1'b0;
    endtask

    // {legal, value} of a CSR as the architecture defines it right now
    function automatic logic [32:0] mread(input logic [11:0] a);
        logic [63:0] mt;
        logic tip;
        mt = ncyc / 64'(TD);
        tip = mt >= m_cmp;
        case (a)
            12'h300: return {1'b1, m_mst};
            12'h304: return {1'b1, m_mie};
            12'h344: return {1'b1, 20'b0, irq_h2, 3'b0, tip, 7'b0};
            12'h305: return {1'b1, m_mtvec};
            12'h340: return {1'b1, m_mscratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'hF14: return {1'b1, 32'd5};
            12'h7C0: return {1'b1, m_cmp[31:0]};
            12'h7C1: return {1'b1, m_cmp[63:32]};
            12'hB00, 12'hC00: return {1'b1, m_cyc[31:0]};
            12'hB80, 12'hC80: return {1'b1, m_cyc[63:32]};
            12'hB02, 12'hC02: return {1'b1, m_ins[31:0]};
            12'hB82, 12'hC82: return {1'b1, m_ins[63:32]};
            12'hC01: return {1'b1, mt[31:0]};
            12'hC81: return {1'b1, mt[63:32]};
            default: return 33'b0;
        endcase
    endfunction

    function automatic logic [31:0] csr_i(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r);
        return {a, r, f3, 5'd1, 7'h73};
    endfunction

    // one cycle with the core in normal flow: drive, sample, check, then advance the model
    task automatic step(input logic v, input logic [31:0] i, input logic [31:0] r, input logic ret);
        logic [32:0] rd;
        logic [31:0] src, nv;
        logic [11:0] a;
        logic csr, wr, ro, ill, do_w, ec, mr, fi;
        instr_vld = v; instr = i; rs0_word = r; retire = ret;
        #1;
        o_jv = jump_vld; o_jpc = jump_pc; o_treq = trap_req; o_ill = csr_illegal; o_data = csr_data; o_n = ncyc;
        a = i[31:20];
        csr = v && i[6:0] == 7'h73 && i[13:12] != 2'b00;
        ec = v && i == 32'h0000_0073;
        mr = v && i == 32'h3020_0073;
        fi = v && i[6:0] == 7'h0F && i[14:12] == 3'b001;
        rd = mread(a);
        src = i[14] ? {27'b0, i[19:15]} : r;
        wr = i[13:12] == 2'b01 || i[19:15] != 5'd0;
        ro = a[11:8] == 4'hC || a == 12'hF14;
        ill = csr && (!rd[32] || (wr && ro));
        do_w = csr && !ill && wr;
        nv = i[13:12] == 2'b01 ? src : i[13:12] == 2'b10 ? rd[31:0] | src : rd[31:0] & ~src;
        if (csr) begin
            chk($sformatf("ill_%h", a), o_ill, ill);
            chk($sformatf("rd_%h", a), o_data, ill ? 32'h0 : rd[31:0]);
        end else chk("ill_quiet", o_ill, 0);
        if (v) begin
            chk("jump_vld", o_jv, ec || mr || fi);
            if (ec || mr || fi) chk("jump_pc", o_jpc, ec ? m_mtvec & ~32'd3 : mr ? m_mepc : pc + 32'd4);
        end
        @(posedge clk);
        ncyc++;
        irq_h2 = irq_h1; irq_h1 = irq_ext;
        m_cyc = do_w && a == 12'hB00 ? {m_cyc[63:32], nv} : do_w && a == 12'hB80 ? {nv, m_cyc[31:0]} : m_cyc + 64'd1;
        m_ins = do_w && a == 12'hB02 ? {m_ins[63:32], nv} : do_w && a == 12'hB82 ? {nv, m_ins[31:0]} : m_ins + 64'(ret);
        if (do_w) begin
            case (a)
                12'h300: m_mst = nv & 32'h88;
                12'h304: m_mie = nv & 32'h880;
                12'h305: m_mtvec = nv;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~32'd3;
                12'h342: m_mcause = nv;
                12'h7C0: m_cmp[31:0] = nv;
                12'h7C1: m_cmp[63:32] = nv;
                default: ;
            endcase
        end
        if (ec) begin
            m_mepc = pc & ~32'd3; m_mcause = 32'd11; m_mst = m_mst[3] ? 32'h80 : 32'h0;
        end
        if (mr) m_mst = m_mst[7] ? 32'h88 : 32'h80;
        @(negedge clk);
    endtask

    task automatic take(input logic [4:0] cause, input logic [31:0] tpc);
        m_mepc = tpc & ~32'd3;
        m_mcause = {1'b1, 26'b0, cause};
        m_mst = m_mst[3] ? 32'h80 : 32'h0;
    endtask

    task automatic wait_treq(input int lim, output logic [63:0] at);
        at = '1;
        for (int k = 0; k < lim && at == '1; k++) begin
            step(1'b0, 32'h0, 32'h0, 1'b0);
            if (o_treq) at = o_n;
        end
    endtask

    task automatic ack(input logic [31:0] tpc, input logic [4:0] cause);
        trap_ack = 1'b1; trap_pc = tpc;
        step(1'b0, 32'h0, 32'h0, 1'b0);
        trap_ack = 1'b0;
        take(cause, tpc);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1 model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [63:0] at;
        model_reset();
        instr_vld = 1'b1; instr = 32'h0000_0073;
        #3;
        chk("rst_treq", trap_req, 0);
        chk("rst_jv", jump_vld, 0);
        chk("rst_jpc", jump_pc, 0);
        chk("rst_ill", csr_illegal, 0);
        instr_vld = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, csr_i(3'd1, 12'h340, 5'd2), 32'hDEAD_BEEF, 1'b0);
        step(1'b1, csr_i(3'd2, 12'h340, 5'd2), 32'h1, 1'b0);
        chk("scratch_old", o_data, 32'hDEAD_BEEF);
        step(1'b1, csr_i(3'd2, 12'h340, 5'd0), 32'h0, 1'b0);
        chk("scratch", o_data, 32'hDEAD_BEEF);
        step(1'b1, csr_i(3'd1, 12'hC00, 5'd3), 32'h5, 1'b0);
        chk("cycle_ro", o_ill, 1);
        step(1'b1, csr_i(3'd2, 12'hB00, 5'd0), 32'h0, 1'b0);
        chk("cycle_cnt", o_data, o_n);
        step(1'b1, csr_i(3'd1, 12'h305, 5'd1), 32'h200, 1'b0);
        step(1'b1, csr_i(3'd2, 12'h300, 5'd1), 32'h8, 1'b0);
        pc = 32'h40;
        step(1'b1, 32'h0000_0073, 32'h0, 1'b0);
        chk("ecall_pc", o_jpc, 32'h200);
        step(1'b1, csr_i(3'd2, 12'h300, 5'd0), 32'h0, 1'b0);
        chk("ecall_mst", o_data, 32'h80);
        step(1'b1, 32'h3020_0073, 32'h0, 1'b0);
        chk("mret_pc", o_jpc, 32'h40);
        step(1'b1, csr_i(3'd2, 12'h300, 5'd0), 32'h0, 1'b0);
        chk("mret_mst", o_data, 32'h88);
        pc = 32'h100;
        step(1'b1, 32'h0000_100F, 32'h0, 1'b0);
        chk("fence_pc", o_jpc, 32'h104);
        for (int n = 0; n < 300; n++) begin
            logic [2:0] f3;
            logic [4:0] fld;
            f3 = 3'($urandom_range(1, 7));
            if (f3 == 3'd4) f3 = 3'd5;
            fld = $urandom_range(0, 2) == 0 ? 5'd0 : 5'($urandom);
            step($urandom_range(0, 9) != 0, csr_i(f3, alist[$urandom_range(0, 21)], fld), $urandom, 1'($urandom));
        end
        do_reset();
        step(1'b1, csr_i(3'd1, 12'h7C1, 5'd1), 32'h0, 1'b0);
        step(1'b1, csr_i(3'd1, 12'h7C0, 5'd1), 32'h2, 1'b0);
        step(1'b1, csr_i(3'd1, 12'h305, 5'd1), 32'h101, 1'b0);
        step(1'b1, csr_i(3'd1, 12'h304, 5'd1), 32'h80, 1'b0);
        step(1'b1, csr_i(3'd1, 12'h300, 5'd1), 32'h8, 1'b0);
        wait_treq(30, at);
        chk("timer_latency", at, 64'(2 * TD + 1));
        ack(32'h80, 5'd7);
        step(1'b0, 32'h0, 32'h0, 1'b0);
        chk("enter_jv", o_jv, 1);
        chk("enter_pc", o_jpc, 32'h11C);
        step(1'b0, 32'h0, 32'h0, 1'b0);
        chk("enter_once", o_jv, 0);
        step(1'b1, csr_i(3'd2, 12'h341, 5'd0), 32'h0, 1'b0);
        chk("tmr_mepc", o_data, 32'h80);
        step(1'b1, csr_i(3'd2, 12'h342, 5'd0), 32'h0, 1'b0);
        chk("tmr_mcause", o_data, 32'h8000_0007);
        step(1'b1, csr_i(3'd2, 12'hC01, 5'd0), 32'h0, 1'b0);
        irq_ext = 1'b1;
        step(1'b1, csr_i(3'd1, 12'h304, 5'd1), 32'h880, 1'b0);
        step(1'b1, csr_i(3'd2, 12'h344, 5'd0), 32'h0, 1'b0);
        step(1'b1, csr_i(3'd2, 12'h300, 5'd1), 32'h8, 1'b0);
        wait_treq(10, at);
        chk("ext_seen", at != '1, 1);
        ack(32'h84, 5'd11);
        step(1'b0, 32'h0, 32'h0, 1'b0);
        chk("ext_pc", o_jpc, 32'h12C);
        step(1'b1, csr_i(3'd2, 12'h342, 5'd0), 32'h0, 1'b0);
        chk("ext_mcause", o_data, 32'h8000_000B);
        irq_ext = 1'b0;
        step(1'b1, csr_i(3'd2, 12'h300, 5'd1), 32'h8, 1'b0);
        wait_treq(10, at);
        chk("req_again", at != '1, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_treq", trap_req, 0);
        chk("arst_jv", jump_vld, 0);
        chk("arst_jpc", jump_pc, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, csr_i(3'd2, 12'h300, 5'd0), 32'h0, 1'b0);
        chk("arst_mie", o_data, 0);
        step(1'b0, 32'h0, 32'h0, 1'b0);
        chk("arst_idle", o_treq, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sys_csr_trap.md
SYS_CSR_TRAP -- requirements
Module: sys_csr_trap

Interface
REQ-001 SHALL take parameter XLEN, default 32, meaning CSR and data width.
REQ-002 SHALL take parameter CNT_W, default 64, meaning width of mcycle/minstret/mtime, range 33..64.
REQ-003 SHALL take parameter TIME_DIV, default 100, meaning clk cycles per mtime tick, minimum 2.
REQ-004 SHALL take parameter HARTID, default 0, meaning mhartid read value.
REQ-005 SHALL take parameter VEC_EN, default 1, meaning 1 permits mtvec vectored mode.
REQ-006 SHALL have these ports: clk  in  1  clock, all state on rising edge.
REQ-007 SHALL have rst  in  1  asynchronous active-low reset.
REQ-008 SHALL have instr_vld  in  1, instr/pc valid this cycle.
REQ-009 SHALL have instr  in  XLEN, issued instruction.
REQ-010 SHALL have pc  in  XLEN, pc of instr.
REQ-011 SHALL have rs0_word  in  XLEN, rs1 operand value.
REQ-012 SHALL have retire  in  1, one instruction retired this cycle.
REQ-013 SHALL have irq_ext  in  1, asynchronous external interrupt level.
REQ-014 SHALL have trap_ack  in  1, pipeline drained, trap_pc valid.
REQ-015 SHALL have trap_pc  in  XLEN, pc of the oldest unissued instruction.
REQ-016 SHALL have trap_req  out  1, interrupt entry requested.
REQ-017 SHALL have jump_vld  out  1, redirect fetch.
REQ-018 SHALL have jump_pc  out  XLEN, redirect target.
REQ-019 SHALL have csr_data  out  XLEN, old CSR value for rd.
REQ-020 SHALL have csr_illegal  out  1, CSR access illegal.

Function
REQ-021 SHALL decode CSR ops (opcode 1110011, funct3!=0) only when instr_vld=1: csrrw/s/c and immediate forms, with csr_data being the pre-write value combinationally.
REQ-022 SHALL implement mstatus(0x300 MIE bit3, MPIE bit7, other bits read 0), mie(0x304 MEIE bit11, MTIE bit7), mip(0x344 read-only), mtvec(0x305), mscratch(0x340), mepc(0x341, bits[1:0] read 0), mcause(0x342), mhartid(0xF14), mtimecmp/mtimecmph(0x7C0/0x7C1).
REQ-023 SHALL implement mcycle/h (0xB00/0xB80) and minstret/h (0xB02/0xB82) writable, and cycle/time/instret (0xC00/0xC01/0xC02, high 0xC80/0xC81/0xC82) read-only; high halves SHALL return counter bits [CNT_W-1:32] zero-extended.
REQ-024 SHALL assert csr_illegal for an unimplemented address, or for a write (csrrw, or set/clear with nonzero rs1/uimm) to 0xC__/0xF14; an illegal access SHALL write nothing and return csr_data=0.
REQ-025 SHALL make a same-cycle CSR write to a counter take priority over its increment.
REQ-026 SHALL increment minstret by one when retire=1, and increment mcycle every cycle.
REQ-027 SHALL pulse a prescaler tick every TIME_DIV cycles, incrementing mtime by one at each tick, with wrap at 2^CNT_W.
REQ-028 SHALL set MTIP to (mtime >= {mtimecmph,mtimecmp}) unsigned.
REQ-029 SHALL set MEIP to irq_ext after a 2-flop synchroniser.
REQ-030 SHALL define ecall as: mepc<=pc, mcause<=11, MPIE<=MIE, MIE<=0, jump_vld=1, jump_pc=mtvec base (mtvec[1:0] cleared).
REQ-031 SHALL define mret as: MIE<=MPIE, MPIE<=1, jump_pc=mepc.
REQ-032 SHALL define fence.i as: jump_pc=pc+4; jump_vld SHALL be asserted combinationally in the same cycle.
REQ-033 SHALL use an FSM with states IDLE, REQ, ENTER.
REQ-034 SHALL transition IDLE->REQ when MIE & (MEIE&MEIP | MTIE&MTIP).
REQ-035 SHALL hold trap_req=1 in REQ until trap_ack.
REQ-036 SHALL on ack latch mepc<=trap_pc, set mcause<={1,cause} with ext(11) over timer(7), set MPIE<=MIE, MIE<=0, then go to ENTER.
REQ-037 SHALL in ENTER drive jump_vld=1 for one cycle, then return to IDLE.
REQ-038 SHALL set the interrupt target to base+4*cause when mtvec[0]=1 & VEC_EN, else base.
REQ-039 SHALL ignore instr_vld in REQ/ENTER; in REQ, if the pending condition clears before ack, the FSM SHALL return to IDLE without trapping.

Reset
REQ-040 SHALL on rst=0 asynchronously clear all CSRs, counters, prescaler, synchroniser and FSM (IDLE).
REQ-041 SHALL set mtimecmp to all-ones at reset.
REQ-042 SHALL hold outputs at reset as trap_req=0, jump_vld=0, jump_pc=0, csr_illegal=0; reset mid-REQ/ENTER SHALL drop trap_req and redirect immediately.

Structure
REQ-043 SHALL place CSR address constants, mcause codes and mstatus/mie bit positions in the shared define package.
REQ-044 SHALL implement one sub-module, sys_csr_timer (prescaler, mtime, mtimecmp compare).

Verification
REQ-045 SHALL cover: csrrw 0x340 with rs0=0xDEADBEEF, then csrrs rs0=0x1 -> second csr_data=0xDEADBEEF, mscratch=0xDEADBEEF.
REQ-046 SHALL cover: csrrw to 0xC00 -> csr_illegal=1, counter unaffected.
REQ-047 SHALL cover: mtvec=0x101, MIE=1, MTIE=1, mtimecmp=2, TIME_DIV=4 -> trap_req ~8 cycles later; ack with trap_pc=0x80 -> mepc=0x80, mcause=0x80000007, jump_pc=0x11C.
REQ-048 SHALL cover: irq_ext and timer pending together -> mcause=0x8000000B.
REQ-049 SHALL cover: ecall at pc=0x40, then mret -> jump_pc=mtvec base, then 0x40; MIE restored.
REQ-050 SHALL cover: rst low while in REQ -> trap_req=0 same cycle, MIE=0, FSM IDLE.
